// File: rtl/wb_host_arbiter.sv
// Two-master Wishbone arbiter: management (m0) and debug (m1) masters share one
// slave port with round-robin tie-break, single-beat transfers and a no-ack timeout.
module wb_host_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        last_gnt, last_gnt_nxt;
    logic [9:0]  tmo_cnt, tmo_cnt_nxt;

    logic        req0, req1, sel_m1, tmo_hit;
    logic        cur_cyc, cur_stb, cur_we;
    logic [31:0] cur_adr, cur_dat;
    logic [3:0]  cur_sel;
    logic        mst_ack;
    logic [31:0] mst_dat;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign sel_m1  = (state == GNT1);
    assign tmo_hit = (tmo_cnt == 10'(TIMEOUT - 1));

    assign cur_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign cur_stb = sel_m1 ? m1_stb_i : m0_stb_i;
    assign cur_we  = sel_m1 ? m1_we_i  : m0_we_i;
    assign cur_adr = sel_m1 ? m1_adr_i : m0_adr_i;
    assign cur_dat = sel_m1 ? m1_dat_i : m0_dat_i;
    assign cur_sel = sel_m1 ? m1_sel_i : m0_sel_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
        end
    end

    // Outputs are decoded as IDLE while reset is high so an in-flight grant
    // is silenced in the reset cycle itself, not one cycle later.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        tmo_cnt_nxt  = '0;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        s_sel_o      = '0;
        grant_o      = 2'b00;
        timeout_o    = 1'b0;
        mst_ack      = 1'b0;
        mst_dat      = '0;
        unique case (wb_rst_i ? IDLE : state)
            IDLE: begin
                if (req0 && req1) state_nxt = last_gnt ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                grant_o = sel_m1 ? 2'b10 : 2'b01;
                s_cyc_o = cur_cyc;
                s_stb_o = cur_stb;
                s_we_o  = cur_we;
                s_adr_o = cur_adr;
                s_dat_o = cur_dat;
                s_sel_o = cur_sel;
                if (!cur_cyc) begin
                    // master abandoned the cycle: release without acking it
                    state_nxt    = IDLE;
                    last_gnt_nxt = sel_m1;
                end else if (s_ack_i) begin
                    mst_ack      = 1'b1;
                    mst_dat      = s_dat_i;
                    state_nxt    = IDLE;
                    last_gnt_nxt = sel_m1;
                end else if (tmo_hit) begin
                    s_cyc_o      = 1'b0;
                    s_stb_o      = 1'b0;
                    mst_ack      = 1'b1;
                    mst_dat      = ERR_DATA;
                    timeout_o    = 1'b1;
                    state_nxt    = IDLE;
                    last_gnt_nxt = sel_m1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 10'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_ack_o = mst_ack & ~sel_m1;
    assign m1_ack_o = mst_ack &  sel_m1;
    assign m0_dat_o = sel_m1 ? 32'h0 : mst_dat;
    assign m1_dat_o = sel_m1 ? mst_dat : 32'h0;
endmodule

// File: tb/tb_wb_host_arbiter.sv
// Directed bench for wb_host_arbiter (TIMEOUT = 8): inputs change 1 ns after
// the rising edge, outputs are checked on the falling edge.
module tb_wb_host_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack, tmo;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_host_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic m0_req(input logic on, input logic we, input logic [31:0] adr);
        m0_cyc = on; m0_stb = on; m0_we = we; m0_adr = adr;
    endtask

    task automatic m1_req(input logic on, input logic we, input logic [31:0] adr);
        m1_cyc = on; m1_stb = on; m1_we = we; m1_adr = adr;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_scyc"}, 32'(s_cyc), 32'h0);
        chk({tag, "_sstb"}, 32'(s_stb), 32'h0);
        chk({tag, "_sadr"}, s_adr, 32'h0);
        chk({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'h0);
        chk({tag, "_tmo"}, 32'(tmo), 32'h0);
    endtask

    initial begin
        rst = 1'b1; s_ack = 1'b0; s_rdat = '0;
        m0_req(0, 0, 0); m1_req(0, 0, 0);
        m0_wdat = 32'h0BAD_F00D; m1_wdat = 32'hA5A5_0001;
        m0_sel = 4'hF; m1_sel = 4'h3;
        step(); step();
        smp(); chk_quiet("rst");

        // single read from m0, slave answers two cycles after strobe
        step(); rst = 1'b0; m0_req(1, 0, 32'h3000_0000);
        smp(); chk("t1_idle_stb", 32'(s_stb), 32'h0);
        step();
        smp(); chk("t1_stb", 32'(s_stb), 32'h1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_adr", s_adr, 32'h3000_0000);
        chk("t1_sel", 32'(s_sel), 32'hF);
        chk("t1_noack", 32'(m0_ack), 32'h0);
        step(); smp(); chk("t1_wait", 32'(m0_ack), 32'h0);
        step(); s_ack = 1'b1; s_rdat = 32'h1234_5678;
        smp(); chk("t1_ack", 32'(m0_ack), 32'h1);
        chk("t1_dat", m0_rdat, 32'h1234_5678);
        chk("t1_m1dat", m1_rdat, 32'h0);
        step(); s_ack = 1'b0; m0_req(0, 0, 0);
        smp(); chk_quiet("t1_post");

        // simultaneous requests after reset: m0, one idle cycle, m1, then m0 again
        rst = 1'b1; step(); rst = 1'b0;
        m0_req(1, 0, 32'h0000_0A00); m1_req(1, 0, 32'h0000_0B00);
        step(); s_ack = 1'b1; s_rdat = 32'h0000_00A0;
        smp(); chk("t2_g0", 32'(grant), 32'h1);
        chk("t2_adr0", s_adr, 32'h0000_0A00);
        chk("t2_ack0", 32'({m0_ack, m1_ack}), 32'h2);
        step(); s_ack = 1'b0; m0_req(0, 0, 0);
        smp(); chk("t2_gap", 32'({grant, s_stb}), 32'h0);
        step(); s_ack = 1'b1; s_rdat = 32'h0000_00B0;
        smp(); chk("t2_g1", 32'(grant), 32'h2);
        chk("t2_adr1", s_adr, 32'h0000_0B00);
        chk("t2_ack1", 32'({m0_ack, m1_ack}), 32'h1);
        chk("t2_dat1", m1_rdat, 32'h0000_00B0);
        step(); s_ack = 1'b0; m1_req(0, 0, 0);
        m0_req(1, 0, 32'h0000_0A04); m1_req(1, 0, 32'h0000_0B04);
        step(); s_ack = 1'b1;
        smp(); chk("t2_rr", 32'(grant), 32'h1);
        step(); s_ack = 1'b0; m0_req(0, 0, 0); m1_req(0, 0, 0);

        // m1 write that the slave never acks: error ack in the 8th grant cycle
        m1_req(1, 1, 32'h0000_0C00);
        step();
        for (int k = 0; k < 7; k++) begin
            smp();
            if (k == 0) chk("t3_we", 32'(s_we), 32'h1);
            if (k == 0) chk("t3_wdat", s_wdat, 32'hA5A5_0001);
            chk($sformatf("t3_wait%0d", k), 32'({grant, s_cyc, m1_ack, tmo}), 32'h14);
            step();
        end
        smp(); chk("t3_tmo", 32'({grant, s_cyc, m1_ack, tmo}), 32'h13);
        chk("t3_err", m1_rdat, 32'hDEADBEEF);
        step(); m1_req(0, 0, 0);
        smp(); chk_quiet("t3_post");

        // slave ack on the last allowed cycle beats the timeout
        m0_req(1, 0, 32'h0000_0D00);
        step();
        for (int k = 0; k < 7; k++) step();
        s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
        smp(); chk("t4_ack", 32'({m0_ack, tmo, s_cyc}), 32'h5);
        chk("t4_dat", m0_rdat, 32'hCAFE_F00D);
        step(); s_ack = 1'b0; m0_req(0, 0, 0);

        // reset pulse during a GNT1 transfer
        m1_req(1, 0, 32'h0000_0E00);
        step(); smp(); chk("t5_g1", 32'(grant), 32'h2);
        step(); rst = 1'b1; s_ack = 1'b1;
        smp(); chk_quiet("t5_inrst");
        step(); rst = 1'b0; m0_req(1, 0, 32'h0000_0E04);
        smp(); chk_quiet("t5_after");
        step(); smp(); chk("t5_tie", 32'({grant, m0_ack}), 32'h3);
        step(); s_ack = 1'b0; m0_req(0, 0, 0); m1_req(0, 0, 0);

        // m0 drops cyc mid-grant while m1 waits
        m0_req(1, 0, 32'h0000_0F00);
        step(); smp(); chk("t6_g0", 32'(grant), 32'h1);
        step(); m0_req(0, 0, 0); m1_req(1, 0, 32'h0000_0F04); s_ack = 1'b1;
        smp(); chk("t6_abort", 32'({m0_ack, s_cyc}), 32'h0);
        step(); s_ack = 1'b0;
        smp(); chk("t6_idle", 32'({grant, m0_ack}), 32'h0);
        step(); s_ack = 1'b1; s_rdat = 32'h0000_0F0F;
        smp(); chk("t6_g1", 32'({grant, m0_ack, m1_ack}), 32'h9);
        step(); s_ack = 1'b0; m1_req(0, 0, 0);
        smp(); chk_quiet("t6_post");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wb_host_arbiter.md
WB_HOST_ARBITER -- requirements
Module: wb_host_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: grant cycles without slave ack before forced termination; legal range 2..1023.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned to the master on timeout.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (management Wishbone) cycle, strobe and write-enable.
REQ-006 m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data; m0_sel_i  in  4  byte selects.
REQ-007 m0_dat_o  out  32  master 0 read data; m0_ack_o  out  1  master 0 acknowledge.
REQ-008 m1_* (cyc, stb, we, adr, dat_i, sel, dat_o, ack)  same directions and widths as REQ-005..007; master 1 (logic-analyzer debug master).
REQ-009 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared downstream slave port controls.
REQ-010 s_adr_o, s_dat_o  out  32 each; s_sel_o  out  4  forwarded from the granted master.
REQ-011 s_dat_i  in  32  slave read data; s_ack_i  in  1  slave acknowledge.
REQ-012 grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); timeout_o  out  1  one-cycle timeout pulse.

Function
REQ-013 FSM states IDLE, GNT0, GNT1; one-hot encoding not required.
REQ-014 Request n = mn_cyc_i & mn_stb_i.
REQ-015 IDLE: no request -> stay; single request -> GNTn next cycle; both requests -> master other than last_gnt wins.
REQ-016 last_gnt register updates to n on every exit from GNTn (ack, timeout or abort).
REQ-017 Grant latency: request sampled at edge t -> s_cyc_o/s_stb_o high from cycle t+1.
REQ-018 In GNTn, s_cyc_o = mn_cyc_i, s_stb_o = mn_stb_i; s_we/adr/dat/sel combinationally forwarded from master n.
REQ-019 In IDLE, s_cyc_o = s_stb_o = 0 and s_adr/dat/sel/we = 0.
REQ-020 In GNTn, s_ack_i = 1 -> mn_ack_o = 1 and mn_dat_o = s_dat_i in the same cycle; FSM -> IDLE next edge.
REQ-021 Ungranted master: ack_o = 0, dat_o = 0 at all times.
REQ-022 Each transfer is a single beat; back-to-back requests pass through IDLE for one cycle each (minimum 2 cycles between s_stb_o assertions from distinct transfers).
REQ-023 Counter tmo_cnt (10 bits) clears on entry to GNTn and increments each GNTn cycle without s_ack_i.
REQ-024 tmo_cnt == TIMEOUT-1 with no ack -> that cycle: s_cyc_o = s_stb_o = 0, mn_ack_o = 1, mn_dat_o = ERR_DATA, timeout_o = 1; FSM -> IDLE next edge.
REQ-025 s_ack_i on the timeout cycle takes priority: normal ack, no timeout_o.
REQ-026 Master drops mn_cyc_i while in GNTn -> no ack to it; FSM -> IDLE next edge; last_gnt = n.
REQ-027 s_ack_i in IDLE is ignored: no master ack generated.
REQ-028 grant_o = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.

Reset
REQ-029 wb_rst_i high at an edge -> state IDLE, last_gnt = 1 (m0 wins first tie), tmo_cnt = 0.
REQ-030 During and after reset: all s_* outputs 0, m0/m1 ack_o = 0, dat_o = 0, grant_o = 0, timeout_o = 0.
REQ-031 Reset asserted mid-transfer aborts it; no ack is issued to the in-flight master.

Verification
REQ-032 m0 read adr 0x3000_0000, slave acks 2 cycles after s_stb_o with 0x1234_5678 -> s_stb_o at t+1, m0_ack_o with m0_dat_o = 0x1234_5678 in the slave-ack cycle, grant_o = 01.
REQ-033 m0 and m1 request in the same cycle after reset, both held -> m0 served first, then m1 after exactly one IDLE cycle; next simultaneous request served to m0 (round-robin).
REQ-034 m1 write, slave never acks, TIMEOUT = 8 -> m1_ack_o with m1_dat_o = 0xDEADBEEF 8 cycles after grant, timeout_o one pulse, s_cyc_o low in that cycle.
REQ-035 Slave acks exactly on cycle TIMEOUT-1 -> normal data returned, timeout_o stays 0.
REQ-036 wb_rst_i asserted for 1 cycle while GNT1 active -> next cycle all outputs 0, no m1 ack, then m0 wins the following tie.
REQ-037 m0 drops cyc mid-grant while m1 requests -> IDLE, then m1 granted; no ack ever to m0.
